// File: rtl/ram_master.sv
// ram_master: initiator-side sequencer for the clockless 16-bit word RAM.
//
// Accepts single or burst read/write commands, drives the RAM address,
// data_in, write_enable and read_enable pins, and returns read data over a
// backpressured response stream. Every output is registered and cleared by
// the asynchronous active-low reset.
//
// Ports:
//   i_clk, i_rst_n                          clock, async active-low reset
//   i_req_valid/o_req_ready                 command handshake
//   i_req_write, i_req_addr, i_req_len      command: direction, start, beats-1
//   i_wr_valid/o_wr_ready, i_wr_data        write beat stream
//   o_rd_valid/i_rd_ready, o_rd_data        read beat stream
//   o_done, o_err                           completion pulse and burst error
//   o_ram_address, o_ram_data_in            RAM address / write data
//   o_ram_write_enable, o_ram_read_enable   RAM strobes (never both high)
//   i_ram_data_out                          RAM read data (combinational)
//
// Optional feature: define RAM_MASTER_WRITE_VERIFY_EN to read back every
// in-range written word for READ_LATENCY cycles and flag mismatches in o_err.
module ram_master #(
   parameter int ADDR_W       = 12,
   parameter int DATA_W       = 16,
   parameter int MEM_DEPTH    = 2048,
   parameter int LEN_W        = 4,
   parameter int READ_LATENCY = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_write,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [LEN_W-1:0]  i_req_len,
   input  logic              i_wr_valid,
   output logic              o_wr_ready,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_rd_valid,
   input  logic              i_rd_ready,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_done,
   output logic              o_err,
   output logic [ADDR_W-1:0] o_ram_address,
   output logic [DATA_W-1:0] o_ram_data_in,
   output logic              o_ram_write_enable,
   output logic              o_ram_read_enable,
   input  logic [DATA_W-1:0] i_ram_data_out
);
   typedef enum logic [2:0] {
      S_IDLE, S_WR_DATA, S_WR_PULSE,
`ifdef RAM_MASTER_WRITE_VERIFY_EN
      S_WR_VERIFY,
`endif
      S_RD_ISSUE, S_RD_RESP, S_DONE
   } state_t;
   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [LEN_W-1:0]  r_beats;
   logic              r_err_acc;
   logic [2:0]        r_lat_cnt;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic              w_in_range;
   logic              w_lat_done;
   logic              w_verify;
   logic              w_mismatch;
   logic              w_beat_end;
   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return 32'(a) < MEM_DEPTH;
   endfunction
   always_comb begin
      w_addr_nxt = r_addr + ADDR_W'(1);
      w_in_range = in_range(r_addr);
      w_lat_done = r_lat_cnt == 3'(READ_LATENCY - 1);
`ifdef RAM_MASTER_WRITE_VERIFY_EN
      w_verify   = w_in_range;
      w_mismatch = r_state == S_WR_VERIFY && w_lat_done && i_ram_data_out != o_ram_data_in;
      w_beat_end = (r_state == S_WR_PULSE && !w_verify) || (r_state == S_RD_RESP && i_rd_ready)
                 || (r_state == S_WR_VERIFY && w_lat_done);
`else
      w_verify   = 1'b0;
      w_mismatch = 1'b0;
      w_beat_end = (r_state == S_WR_PULSE) || (r_state == S_RD_RESP && i_rd_ready);
`endif
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state            <= S_IDLE;
         r_addr             <= '0;
         r_beats            <= '0;
         r_err_acc          <= 1'b0;
         r_lat_cnt          <= '0;
         o_req_ready        <= 1'b0;
         o_wr_ready         <= 1'b0;
         o_rd_valid         <= 1'b0;
         o_rd_data          <= '0;
         o_done             <= 1'b0;
         o_err              <= 1'b0;
         o_ram_address      <= '0;
         o_ram_data_in      <= '0;
         o_ram_write_enable <= 1'b0;
         o_ram_read_enable  <= 1'b0;
      end else begin
         o_done <= 1'b0;
         o_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               o_req_ready <= 1'b1;
               if (i_req_valid && o_req_ready) begin
                  o_req_ready <= 1'b0;
                  r_addr      <= i_req_addr;
                  r_beats     <= i_req_len;
                  r_err_acc   <= 1'b0;
                  if (i_req_write) begin
                     o_wr_ready <= 1'b1;
                     r_state    <= S_WR_DATA;
                  end else begin
                     o_ram_address     <= i_req_addr;
                     o_ram_read_enable <= in_range(i_req_addr);
                     r_lat_cnt         <= '0;
                     r_state           <= S_RD_ISSUE;
                  end
               end
            end
            S_WR_DATA: if (i_wr_valid) begin
               o_wr_ready         <= 1'b0;
               o_ram_address      <= r_addr;
               o_ram_data_in      <= i_wr_data;
               o_ram_write_enable <= w_in_range;
               r_err_acc          <= r_err_acc | !w_in_range;
               r_state            <= S_WR_PULSE;
            end
            S_WR_PULSE: begin
               o_ram_write_enable <= 1'b0;
`ifdef RAM_MASTER_WRITE_VERIFY_EN
               if (w_verify) begin
                  o_ram_read_enable <= 1'b1;
                  r_lat_cnt         <= '0;
                  r_state           <= S_WR_VERIFY;
               end
`endif
            end
`ifdef RAM_MASTER_WRITE_VERIFY_EN
            S_WR_VERIFY: begin
               r_lat_cnt <= r_lat_cnt + 3'd1;
               if (w_lat_done) o_ram_read_enable <= 1'b0;
            end
`endif
            S_RD_ISSUE: begin
               r_lat_cnt <= r_lat_cnt + 3'd1;
               if (w_lat_done) begin
                  o_ram_read_enable <= 1'b0;
                  o_rd_data         <= w_in_range ? i_ram_data_out : '0;
                  o_rd_valid        <= 1'b1;
                  r_err_acc         <= r_err_acc | !w_in_range;
                  r_state           <= S_RD_RESP;
               end
            end
            S_RD_RESP: if (i_rd_ready) o_rd_valid <= 1'b0;
            S_DONE: begin
               o_req_ready <= 1'b1;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
         // Shared end-of-beat step: finish the burst or advance to the next address.
         if (w_beat_end) begin
            r_err_acc <= r_err_acc | w_mismatch;
            if (r_beats == '0) begin
               o_done  <= 1'b1;
               o_err   <= r_err_acc | w_mismatch;
               r_state <= S_DONE;
            end else begin
               r_addr  <= w_addr_nxt;
               r_beats <= r_beats - LEN_W'(1);
               if (r_state == S_RD_RESP) begin
                  o_ram_address     <= w_addr_nxt;
                  o_ram_read_enable <= in_range(w_addr_nxt);
                  r_lat_cnt         <= '0;
                  r_state           <= S_RD_ISSUE;
               end else begin
                  o_wr_ready <= 1'b1;
                  r_state    <= S_WR_DATA;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master: directed self-checking bench for ram_master with a behavioural RAM.
module tb_ram_master;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
   logic [11:0] req_addr = '0;
   logic [3:0]  req_len = '0;
   logic        wr_valid = 1'b0, wr_ready;
   logic [15:0] wr_data = '0;
   logic        rd_valid, rd_ready = 1'b0;
   logic [15:0] rd_data;
   logic        done, err;
   logic [11:0] ram_address;
   logic [15:0] ram_data_in, ram_data_out;
   logic        ram_we, ram_re;
   logic [15:0] mem [0:2047];
   logic [15:0] wdat [0:15];
   logic [15:0] rexp [0:15];
   int n_checks = 0, n_errors = 0;
   int n_we = 0, n_re = 0, n_both = 0, n_done = 0, n_dbl = 0;
   logic done_q = 1'b0;
   logic [11:0] we_addr_q [$];
   logic [15:0] we_data_q [$];
   logic e;
   int n0, d0;

   ram_master dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
      .i_req_addr(req_addr), .i_req_len(req_len),
      .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_data(wr_data),
      .o_rd_valid(rd_valid), .i_rd_ready(rd_ready), .o_rd_data(rd_data),
      .o_done(done), .o_err(err),
      .o_ram_address(ram_address), .o_ram_data_in(ram_data_in),
      .o_ram_write_enable(ram_we), .o_ram_read_enable(ram_re),
      .i_ram_data_out(ram_data_out)
   );

   always #5 clk = ~clk;

   assign ram_data_out = ram_re ? mem[ram_address[10:0]] : 16'h0000;
   always @(posedge clk) if (ram_we) mem[ram_address[10:0]] <= ram_data_in;

   always @(negedge clk) begin
      if (ram_we) begin
         n_we++;
         we_addr_q.push_back(ram_address);
         we_data_q.push_back(ram_data_in);
      end
      if (ram_re) n_re++;
      if (ram_we && ram_re) n_both++;
      if (done) n_done++;
      if (done && done_q) n_dbl++;
      done_q = done;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic w, input logic [11:0] a, input logic [3:0] len);
      int t;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_addr = a; req_len = len;
      t = 0;
      while (!req_ready && t < 100) begin @(negedge clk); t++; end
      chk("req_tmo", 64'(t < 100), 1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_done(output logic e_o);
      int t;
      t = 0;
      while (!done && t < 100) begin @(negedge clk); t++; end
      chk("done_tmo", 64'(t < 100), 1);
      e_o = err;
   endtask

   task automatic wr_burst(input logic [11:0] a, input logic [3:0] len, output logic e_o);
      int t;
      issue(1'b1, a, len);
      for (int i = 0; i <= int'(len); i++) begin
         wr_valid = 1'b1; wr_data = wdat[i];
         t = 0;
         while (!wr_ready && t < 100) begin @(negedge clk); t++; end
         chk("wr_tmo", 64'(t < 100), 1);
         @(negedge clk);
      end
      wr_valid = 1'b0;
      wait_done(e_o);
   endtask

   task automatic rd_burst(input logic [11:0] a, input logic [3:0] len, input int stall_beat, output logic e_o);
      int t, r0;
      rd_ready = 1'b1;
      issue(1'b0, a, len);
      for (int i = 0; i <= int'(len); i++) begin
         t = 0;
         while (!rd_valid && t < 100) begin @(negedge clk); t++; end
         chk("rd_tmo", 64'(t < 100), 1);
         chk($sformatf("rd_data[%0d]", i), rd_data, rexp[i]);
         if (i == stall_beat) begin
            rd_ready = 1'b0;
            r0 = n_re;
            repeat (5) begin
               @(negedge clk);
               chk("stall_valid", rd_valid, 1);
               chk("stall_data", rd_data, rexp[i]);
            end
            chk("stall_no_reread", n_re - r0, 0);
            rd_ready = 1'b1;
         end
         @(negedge clk);
      end
      wait_done(e_o);
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
      mem[12'h000] = 16'hA5A5;
      mem[12'h020] = 16'h1234;
      mem[12'h021] = 16'h5678;
      mem[12'h022] = 16'h9ABC;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {req_ready, wr_ready, rd_valid, done, err, ram_we, ram_re,
                            rd_data, ram_address, ram_data_in}, 0);
      rst_n = 1'b1;
      chk("ready_before_edge", req_ready, 0);
      @(negedge clk);
      chk("ready_after_reset", req_ready, 1);

      // single write
      wdat[0] = 16'hBEEF;
      n0 = n_we;
      wr_burst(12'h010, 4'd0, e);
      chk("w1_err", e, 0);
      chk("w1_we_cycles", n_we - n0, 1);
      chk("w1_addr", we_addr_q[n0], 12'h010);
      chk("w1_data", we_data_q[n0], 16'hBEEF);
      @(negedge clk);
      chk("b2b_ready", req_ready, 1);

      // read back
      rexp[0] = 16'hBEEF;
      n0 = n_re;
      rd_burst(12'h010, 4'd0, -1, e);
      chk("r1_err", e, 0);
      chk("r1_re_cycles", n_re - n0, 1);

      // burst crossing the end of implemented memory
      for (int i = 0; i < 4; i++) wdat[i] = 16'((i + 1) * 16'h1111);
      n0 = n_we;
      wr_burst(12'h7FE, 4'd3, e);
      chk("w4_err", e, 1);
      chk("w4_we_cycles", n_we - n0, 2);
      chk("w4_addr0", we_addr_q[n0], 12'h7FE);
      chk("w4_data0", we_data_q[n0], 16'h1111);
      chk("w4_addr1", we_addr_q[n0 + 1], 12'h7FF);
      chk("w4_data1", we_data_q[n0 + 1], 16'h2222);
      chk("w4_mem7ff", mem[12'h7FF], 16'h2222);

      // read wrapping 0xFFF -> 0x000
      rexp[0] = 16'h0000; rexp[1] = 16'hA5A5;
      n0 = n_re;
      rd_burst(12'hFFF, 4'd1, -1, e);
      chk("rwrap_err", e, 1);
      chk("rwrap_re_cycles", n_re - n0, 1);

      // read burst with backpressure on beat 2
      rexp[0] = 16'h1234; rexp[1] = 16'h5678; rexp[2] = 16'h9ABC;
      rd_burst(12'h020, 4'd2, 1, e);
      chk("rstall_err", e, 0);

      // reset in the middle of a 4-beat write burst
      wdat[0] = 16'hDEAD;
      issue(1'b1, 12'h100, 4'd3);
      wr_valid = 1'b1; wr_data = wdat[0];
      @(negedge clk);
      wr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid_wr_ready", wr_ready, 1);
      d0 = n_done;
      #2 rst_n = 1'b0;
      #1 chk("async_reset_outputs", {req_ready, wr_ready, rd_valid, done, err, ram_we, ram_re,
                                     rd_data, ram_address, ram_data_in}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("no_done_after_abort", n_done - d0, 0);
      wdat[0] = 16'hCAFE;
      wr_burst(12'h030, 4'd0, e);
      chk("post_rst_w_err", e, 0);
      rexp[0] = 16'hCAFE;
      rd_burst(12'h030, 4'd0, -1, e);
      chk("post_rst_r_err", e, 0);

      @(negedge clk);
      chk("enables_exclusive", n_both, 0);
      chk("done_one_cycle", n_dbl, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/ram_master.md
Name: ram_master

Overview:
- Initiator-side controller for the microcpu's 16-bit word RAM.
- Accepts single or burst read/write commands from the CPU/DMA side and sequences the RAM's address, data_in, write_enable and read_enable pins.
- Captures the RAM's data_out and returns it over a backpressured response stream.
- Sits between the CPU load/store path and the ram block. The RAM has no clock and a combinational read path; this block provides all sequencing.

Parameters:
- ADDR_W, 12: RAM address width.
- DATA_W, 16: word width.
- MEM_DEPTH, 2048: number of implemented words. Addresses >= MEM_DEPTH are out of range.
- LEN_W, 4: burst length field width. A burst is req_len+1 beats, 1..16.
- READ_LATENCY, 1: cycles ram_read_enable is held before ram_data_out is sampled (range 1..7).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when req_valid && req_ready.
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_W  start word address.
- req_len  in  LEN_W  beats minus one.
- wr_valid  in  1  write data beat valid.
- wr_ready  out  1  write beat accepted when wr_valid && wr_ready.
- wr_data  in  DATA_W  write beat data.
- rd_valid  out  1  read beat valid.
- rd_ready  in  1  consumer accepts the read beat.
- rd_data  out  DATA_W  read beat data.
- done  out  1  one-cycle pulse at burst completion.
- err  out  1  valid with done; 1 if any beat of the burst was out of range (or failed verify).
- ram_address  out  ADDR_W  to RAM address.
- ram_data_in  out  DATA_W  to RAM data_in.
- ram_write_enable  out  1  to RAM write_enable.
- ram_read_enable  out  1  to RAM read_enable.
- ram_data_out  in  DATA_W  from RAM data_out.

Behaviour:
- Reset:
  - Asynchronous, active-low: all outputs are registered and clear to 0 immediately.
  - FSM returns to IDLE. Reset mid-burst abandons the burst; no done is issued.
  - ram_*_enable drop in the same instant reset asserts.
- States: IDLE, WR_DATA, WR_PULSE, WR_VERIFY (only with the optional feature), RD_ISSUE, RD_RESP, DONE.
- IDLE:
  - req_ready=1 (registered; 1 from the cycle after reset deasserts).
  - On handshake: latch addr, write, beats=req_len, clear the err accumulator.
  - Go to WR_DATA or RD_ISSUE. req_ready=0 in every other state.
- WR_DATA:
  - wr_ready=1.
  - On wr_valid: register ram_address=addr and ram_data_in=wr_data, then go to WR_PULSE.
- WR_PULSE:
  - ram_write_enable=1 for exactly one cycle; address and data are stable during that cycle.
  - If addr >= MEM_DEPTH: enable stays 0 and err_acc is set.
  - Then: if beats==0 go to DONE; else addr=addr+1 mod 2^ADDR_W, beats-=1, go to WR_DATA.
  - Minimum 2 cycles per write beat.
- RD_ISSUE:
  - ram_address=addr and ram_read_enable=1, held for READ_LATENCY cycles.
  - On the last cycle, rd_data is loaded from ram_data_out; go to RD_RESP.
  - Out of range: enable stays 0, rd_data=0, err_acc is set.
- RD_RESP:
  - rd_valid=1; rd_data is held stable until rd_ready.
  - On accept: if beats==0 go to DONE; else increment addr, decrement beats, go to RD_ISSUE.
  - ram_read_enable=0 in this state.
- DONE:
  - done=1 and err=err_acc for one cycle, then IDLE.
  - Back-to-back: the next command is accepted the cycle after DONE.
- Never assert ram_write_enable and ram_read_enable in the same cycle.
- Address wraps 4095->0 within a burst; each beat is range-checked individually.
- rd_ready asserted outside RD_RESP has no effect. wr_valid outside WR_DATA is not consumed.

Optional Feature:
- Macro: RAM_MASTER_WRITE_VERIFY_EN.
- Defined: after each in-range WR_PULSE, enter WR_VERIFY.
  - Hold ram_read_enable=1 at the same address for READ_LATENCY cycles, then compare ram_data_out with the written word.
  - Mismatch sets err_acc. Then continue as WR_PULSE would.
  - Adds READ_LATENCY cycles per in-range write beat.
- Undefined: the WR_VERIFY state and its logic are absent; writes take 2 cycles per beat.

Test Plan:
- Single write addr=0x010, len=0, wr_data=0xBEEF -> exactly one cycle with ram_write_enable=1, ram_address=0x010, ram_data_in=0xBEEF; done=1, err=0.
- Read-back addr=0x010, len=0, rd_ready=1 -> ram_read_enable held READ_LATENCY cycles; rd_valid with rd_data=0xBEEF; done pulse.
- Burst write addr=0x7FE, len=3, data 0x1111..0x4444 -> beats to 0x7FE and 0x7FF written; 0x800 and 0x801 suppressed (no enable); done with err=1.
- Burst read addr=0xFFF, len=1 -> address wraps to 0x000; beat 1 returns 0x0000 (out of range); beat 2 returns mem[0]; err=1.
- Read burst len=2 with rd_ready low for 5 cycles on beat 2 -> rd_data stable, no new RAM read issued until accept.
- Reset asserted during WR_DATA of a 4-beat burst -> all outputs 0 asynchronously; no done; next command completes normally.
